// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Brings up the system PLL and then releases the downstream clock-domain
// resets one at a time, bit 0 first. The whole sequence re-runs whenever
// the synchronized lock drops after the domains have started releasing.
//
// Build option: define PLL_SEQ_TIMEOUT_EN to build the WAIT_LOCK timeout,
// the retry counter and the terminal FAULT state. Without it the sequencer
// waits for lock indefinitely and retry_cnt / fault are constant zero.
module pll_reset_sequencer #(
    parameter int RST_CYCLES  = 16,
    parameter int LOCK_STABLE = 1024,
    parameter int NUM_DOMAINS = 4,
    parameter int STAGE_GAP   = 8,
    parameter int TIMEOUT     = 65536,
    parameter int MAX_RETRY   = 7
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   ready,
    output logic [2:0]             retry_cnt,
    output logic                   fault
);

    // One counter serves every timed state, so size it for the longest wait.
    localparam int MAX_A = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int MAX_B = (MAX_A > STAGE_GAP) ? MAX_A : STAGE_GAP;
`ifdef PLL_SEQ_TIMEOUT_EN
    localparam int CNT_MAX = (MAX_B > TIMEOUT) ? MAX_B : TIMEOUT;
`else
    localparam int CNT_MAX = MAX_B;
`endif
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]       CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0]       CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]       RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]       STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]       GAP_LAST    = CNT_W'(STAGE_GAP - 1);
    localparam logic [NUM_DOMAINS-1:0] DOM_ONES    = {NUM_DOMAINS{1'b1}};
    localparam logic [NUM_DOMAINS-1:0] DOM_ZERO    = {NUM_DOMAINS{1'b0}};

`ifdef PLL_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]       RETRY_LAST   = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;
`endif

    state_t                   state_r;
    logic [CNT_W-1:0]         cnt_r;
    logic [1:0]               sync_r;
    logic                     locked_s;
    logic                     pll_rst_r;
    logic [NUM_DOMAINS-1:0]   rst_out_r;
    logic [NUM_DOMAINS-1:0]   rst_shift_s;
    logic                     ready_r;
`ifdef PLL_SEQ_TIMEOUT_EN
    logic [2:0]               retry_r;
    logic                     fault_r;
`endif

    // Next staged release pattern: one more low bit, filled from bit 0 upward.
    assign rst_shift_s = rst_out_r << 1'b1;
    assign locked_s    = sync_r[1];

    // Two-flop synchronizer bringing the asynchronous lock into refclk.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], pll_locked};
        end
    end

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_r   <= PLL_RESET;
            cnt_r     <= CNT_ZERO;
            pll_rst_r <= 1'b1;
            rst_out_r <= DOM_ONES;
            ready_r   <= 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
            retry_r   <= 3'd0;
            fault_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                PLL_RESET: begin
                    rst_out_r <= DOM_ONES;
                    ready_r   <= 1'b0;
                    if (cnt_r == RST_LAST) begin
                        state_r   <= WAIT_LOCK;
                        cnt_r     <= CNT_ZERO;
                        pll_rst_r <= 1'b0;
                    end else begin
                        cnt_r     <= cnt_r + CNT_ONE;
                        pll_rst_r <= 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    pll_rst_r <= 1'b0;
                    if (locked_s) begin
                        state_r <= STABLE;
                        cnt_r   <= CNT_ZERO;
`ifdef PLL_SEQ_TIMEOUT_EN
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        cnt_r <= CNT_ZERO;
                        if (retry_r == RETRY_LAST) begin
                            state_r   <= FAULT;
                            pll_rst_r <= 1'b1;
                            fault_r   <= 1'b1;
                        end else begin
                            state_r   <= PLL_RESET;
                            pll_rst_r <= 1'b1;
                            retry_r   <= retry_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
`else
                    end else begin
                        // No timeout: the counter is idle while waiting.
                        cnt_r <= cnt_r;
                    end
`endif
                end
                STABLE: begin
                    if (!locked_s) begin
                        // Any dropout restarts both the stability and timeout counts.
                        state_r <= WAIT_LOCK;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == STABLE_LAST) begin
                        cnt_r     <= CNT_ZERO;
                        rst_out_r <= rst_shift_s;
                        if (rst_shift_s == DOM_ZERO) begin
                            // Single domain: nothing left to stage.
                            state_r <= RUN;
                            ready_r <= 1'b1;
`ifdef PLL_SEQ_TIMEOUT_EN
                            retry_r <= 3'd0;
`endif
                        end else begin
                            state_r <= RELEASE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (!locked_s) begin
                        state_r   <= PLL_RESET;
                        cnt_r     <= CNT_ZERO;
                        pll_rst_r <= 1'b1;
                        rst_out_r <= DOM_ONES;
                        ready_r   <= 1'b0;
                    end else if (cnt_r == GAP_LAST) begin
                        cnt_r     <= CNT_ZERO;
                        rst_out_r <= rst_shift_s;
                        if (rst_shift_s == DOM_ZERO) begin
                            state_r <= RUN;
                            ready_r <= 1'b1;
`ifdef PLL_SEQ_TIMEOUT_EN
                            retry_r <= 3'd0;
`endif
                        end else begin
                            state_r <= RELEASE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_r   <= PLL_RESET;
                        cnt_r     <= CNT_ZERO;
                        pll_rst_r <= 1'b1;
                        rst_out_r <= DOM_ONES;
                        ready_r   <= 1'b0;
                    end else begin
                        state_r <= RUN;
                    end
                end
`ifdef PLL_SEQ_TIMEOUT_EN
                FAULT: begin
                    // Terminal: only the asynchronous reset leaves this state.
                    pll_rst_r <= 1'b1;
                    rst_out_r <= DOM_ONES;
                    ready_r   <= 1'b0;
                    fault_r   <= 1'b1;
                end
`endif
                default: begin
                    state_r   <= PLL_RESET;
                    cnt_r     <= CNT_ZERO;
                    pll_rst_r <= 1'b1;
                    rst_out_r <= DOM_ONES;
                    ready_r   <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst = pll_rst_r;
    assign rst_out = rst_out_r;
    assign ready   = ready_r;
`ifdef PLL_SEQ_TIMEOUT_EN
    assign retry_cnt = retry_r;
    assign fault     = fault_r;
`else
    // TIMEOUT and MAX_RETRY have no effect here; they are folded into a
    // constant zero so both builds share one parameter list.
    assign retry_cnt = 3'd0;
    assign fault     = 1'b0 && (TIMEOUT > 0) && (MAX_RETRY >= 0);
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: each scenario queues the output
// values expected after given refclk edges, and a monitor compares them
// 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

    localparam int ND = 4;

    logic          refclk;
    logic          rst;
    logic          pll_locked;
    logic          pll_rst;
    logic [ND-1:0] rst_out;
    logic          ready;
    logic [2:0]    retry_cnt;
    logic          fault;

    int n_checks = 0;
    int n_fails  = 0;
    int edge_cnt = 0;
    int base     = 0;

    typedef struct {
        int         edge_no;
        string      tag;
        logic [9:0] exp_v;
    } exp_t;

    exp_t exp_q[$];

    pll_reset_sequencer #(
        .RST_CYCLES (4),
        .LOCK_STABLE(8),
        .NUM_DOMAINS(ND),
        .STAGE_GAP  (2),
        .TIMEOUT    (32),
        .MAX_RETRY  (2)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .rst_out   (rst_out),
        .ready     (ready),
        .retry_cnt (retry_cnt),
        .fault     (fault)
    );

    // Reference clock, 10 ns period.
    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    function automatic logic [9:0] pack(input logic pr, input logic [3:0] ro,
                                        input logic rdy, input logic [2:0] rc,
                                        input logic f);
        return {pr, ro, rdy, rc, f};
    endfunction

    function automatic logic [9:0] dut_vec();
        return pack(pll_rst, rst_out, ready, retry_cnt, fault);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (pll_rst,rst_out,ready,retry,fault)",
                     tag, obs, exp);
        end
    endtask

    // Queue an expected output set for edge base+rel (call in edge order).
    task automatic expect_at(input string tag, input int rel, input logic pr,
                             input logic [3:0] ro, input logic rdy,
                             input logic [2:0] rc, input logic f);
        exp_t e;
        e.edge_no = base + rel;
        e.tag     = tag;
        e.exp_v   = pack(pr, ro, rdy, rc, f);
        exp_q.push_back(e);
    endtask

    // Returns at the falling edge that follows rising edge number abs_edge.
    task automatic wait_edge(input int abs_edge);
        while (edge_cnt < abs_edge) @(negedge refclk);
    endtask

    // Monitor: count edges and retire every expectation due on this edge.
    initial begin
        forever begin
            @(posedge refclk);
            edge_cnt++;
            #1;
            while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.edge_no < edge_cnt)
                    check_eq({e.tag, "_missed"}, 32'(edge_cnt), 32'(e.edge_no));
                else
                    check_eq(e.tag, 32'(dut_vec()), 32'(e.exp_v));
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, edge %0d", edge_cnt);
        $fatal(1, "watchdog");
    end

    // Stimulus: scenarios run back to back.
    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        #1;
        check_eq("reset_vals", 32'(dut_vec()), 32'(pack(1'b1, 4'hF, 1'b0, 3'd0, 1'b0)));
        wait_edge(3);
        check_eq("reset_held", 32'(dut_vec()), 32'(pack(1'b1, 4'hF, 1'b0, 3'd0, 1'b0)));

        // Normal bring-up, lock raised after edge 10.
        base = edge_cnt;
        rst  = 1'b0;
        expect_at("boot_prst_e3",  3, 1'b1, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("boot_prst_e4",  4, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("boot_hold_e20", 20, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("boot_rel0_e21", 21, 1'b0, 4'hE, 1'b0, 3'd0, 1'b0);
        expect_at("boot_gap_e22",  22, 1'b0, 4'hE, 1'b0, 3'd0, 1'b0);
        expect_at("boot_rel1_e23", 23, 1'b0, 4'hC, 1'b0, 3'd0, 1'b0);
        expect_at("boot_rel2_e25", 25, 1'b0, 4'h8, 1'b0, 3'd0, 1'b0);
        expect_at("boot_rel2_e26", 26, 1'b0, 4'h8, 1'b0, 3'd0, 1'b0);
        expect_at("boot_run_e27",  27, 1'b0, 4'h0, 1'b1, 3'd0, 1'b0);
        wait_edge(base + 10);
        pll_locked = 1'b1;
        wait_edge(base + 30);

        // Lock loss in RUN, then re-lock.
        base       = edge_cnt;
        pll_locked = 1'b0;
        expect_at("loss_run_e2",  2, 1'b0, 4'h0, 1'b1, 3'd0, 1'b0);
        expect_at("loss_rst_e3",  3, 1'b1, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("loss_prst_e6", 6, 1'b1, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("loss_prst_e7", 7, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("loss_hold_e20", 20, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("loss_rel0_e21", 21, 1'b0, 4'hE, 1'b0, 3'd0, 1'b0);
        expect_at("loss_rel1_e23", 23, 1'b0, 4'hC, 1'b0, 3'd0, 1'b0);
        expect_at("loss_rel2_e25", 25, 1'b0, 4'h8, 1'b0, 3'd0, 1'b0);
        expect_at("loss_run_e27",  27, 1'b0, 4'h0, 1'b1, 3'd0, 1'b0);
        wait_edge(base + 10);
        pll_locked = 1'b1;
        wait_edge(base + 30);

        // One-cycle lock glitch during STABLE restarts the stability count.
        base       = edge_cnt;
        pll_locked = 1'b0;
        expect_at("glt_loss_e3",  3, 1'b1, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("glt_wait_e7",  7, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("glt_e18",     18, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("glt_e19",     19, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("glt_norel_e21", 21, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("glt_hold_e26",  26, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("glt_rel0_e27",  27, 1'b0, 4'hE, 1'b0, 3'd0, 1'b0);
        expect_at("glt_rel1_e29",  29, 1'b0, 4'hC, 1'b0, 3'd0, 1'b0);
        expect_at("glt_rel2_e31",  31, 1'b0, 4'h8, 1'b0, 3'd0, 1'b0);
        expect_at("glt_rel2_e32",  32, 1'b0, 4'h8, 1'b0, 3'd0, 1'b0);
        expect_at("glt_run_e33",   33, 1'b0, 4'h0, 1'b1, 3'd0, 1'b0);
        wait_edge(base + 10);
        pll_locked = 1'b1;
        wait_edge(base + 15);
        pll_locked = 1'b0;
        wait_edge(base + 16);
        pll_locked = 1'b1;
        wait_edge(base + 36);

        // Reset asserted in the middle of RELEASE.
        base       = edge_cnt;
        pll_locked = 1'b0;
        expect_at("mid_loss_e3", 3, 1'b1, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("mid_rel0_e21", 21, 1'b0, 4'hE, 1'b0, 3'd0, 1'b0);
        expect_at("mid_rel1_e23", 23, 1'b0, 4'hC, 1'b0, 3'd0, 1'b0);
        expect_at("mid_rsthold_e25", 25, 1'b1, 4'hF, 1'b0, 3'd0, 1'b0);
        wait_edge(base + 10);
        pll_locked = 1'b1;
        wait_edge(base + 23);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_async", 32'(dut_vec()), 32'(pack(1'b1, 4'hF, 1'b0, 3'd0, 1'b0)));
        pll_locked = 1'b0;
        wait_edge(base + 26);

`ifdef PLL_SEQ_TIMEOUT_EN
        // Timeout retries ending in FAULT, held until reset.
        base = edge_cnt;
        rst  = 1'b0;
        expect_at("to_wait_e4",   4, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("to_e35",      35, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("to_retry1",   36, 1'b1, 4'hF, 1'b0, 3'd1, 1'b0);
        expect_at("to_prst_e39", 39, 1'b1, 4'hF, 1'b0, 3'd1, 1'b0);
        expect_at("to_wait_e40", 40, 1'b0, 4'hF, 1'b0, 3'd1, 1'b0);
        expect_at("to_e71",      71, 1'b0, 4'hF, 1'b0, 3'd1, 1'b0);
        expect_at("to_retry2",   72, 1'b1, 4'hF, 1'b0, 3'd2, 1'b0);
        expect_at("to_wait_e76", 76, 1'b0, 4'hF, 1'b0, 3'd2, 1'b0);
        expect_at("to_e107",    107, 1'b0, 4'hF, 1'b0, 3'd2, 1'b0);
        expect_at("to_fault",   108, 1'b1, 4'hF, 1'b0, 3'd2, 1'b1);
        expect_at("to_fault_held", 140, 1'b1, 4'hF, 1'b0, 3'd2, 1'b1);
        wait_edge(base + 115);
        pll_locked = 1'b1;
        wait_edge(base + 141);
        rst = 1'b1;
        #1;
        check_eq("fault_rst_async", 32'(dut_vec()), 32'(pack(1'b1, 4'hF, 1'b0, 3'd0, 1'b0)));
        pll_locked = 1'b0;
        wait_edge(base + 144);

        // One retry, then lock: RUN entry clears retry_cnt.
        base = edge_cnt;
        rst  = 1'b0;
        expect_at("rc_retry1",  36, 1'b1, 4'hF, 1'b0, 3'd1, 1'b0);
        expect_at("rc_rel0",    51, 1'b0, 4'hE, 1'b0, 3'd1, 1'b0);
        expect_at("rc_rel2",    56, 1'b0, 4'h8, 1'b0, 3'd1, 1'b0);
        expect_at("rc_run_clr", 57, 1'b0, 4'h0, 1'b1, 3'd0, 1'b0);
        wait_edge(base + 40);
        pll_locked = 1'b1;
        wait_edge(base + 60);
`else
        // No timeout: WAIT_LOCK holds indefinitely, later lock releases normally.
        base = edge_cnt;
        rst  = 1'b0;
        expect_at("nt_wait_e4",     4, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("nt_wait_e500", 500, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("nt_wait_e1000", 1000, 1'b0, 4'hF, 1'b0, 3'd0, 1'b0);
        expect_at("nt_rel0",     1011, 1'b0, 4'hE, 1'b0, 3'd0, 1'b0);
        expect_at("nt_rel1",     1013, 1'b0, 4'hC, 1'b0, 3'd0, 1'b0);
        expect_at("nt_run",      1017, 1'b0, 4'h0, 1'b1, 3'd0, 1'b0);
        wait_edge(base + 1000);
        pll_locked = 1'b1;
        wait_edge(base + 1020);
`endif

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
